time_date_counter: RTL
======================

// Module: time_date_counter
// PURPOSE
//   Free-running real-time clock and calendar for the 2000-2099 century clock.
//   Divides the system clock to 1 Hz and keeps second/minute/hour/day/month/year in binary.
//   Handles month lengths and leap years. Accepts a validated full-date load.
//   Its outputs feed the seven-segment decode stage directly, with widths matching that stage.
// PARAMETERS
//   CLK_FREQ   50_000_000  system clock cycles per second; benches use a small value, e.g. 4
// PORTS
//   clk            in   1  system clock, rising edge
//   rst_n          in   1  asynchronous active-low reset
//   run            in   1  1 = timekeeping advances; 0 = prescaler and counters hold
//   set_en         in   1  one-cycle load strobe for all set_* fields
//   set_day        in   5  1..days_in_month(set_month, set_year)
//   set_month      in   4  1..12
//   set_year       in   7  0..99 (year 20xx)
//   set_hour       in   5  0..23
//   set_minute     in   6  0..59
//   set_second     in   6  0..59
//   day            out  5  current day, 1..31
//   month          out  4  current month, 1..12
//   year           out  7  current year, 0..99
//   hour           out  5  0..23
//   minute         out  6  0..59
//   second         out  6  0..59
//   sec_pulse      out  1  high 1 cycle, on the first cycle the new second is visible
//   century_pulse  out  1  high 1 cycle, on the first cycle of the 99->00 rollover
//   set_err        out  1  high 1 cycle, the cycle after a rejected set_en
// BEHAVIOUR
//   Reset (async assert, sync release): 01/01/00 00:00:00; prescaler = 0; all pulses = 0.
//   Prescaler: ceil(log2(CLK_FREQ)) bits; increments each cycle while run=1.
//   - When run=1 and the prescaler is at CLK_FREQ-1, it wraps to 0 and that cycle is a tick.
//   - On tick, all registers update at the same clock edge. The outputs are registered.
//   - Result: latency from the tick cycle to new outputs and sec_pulse is 1 clock.
//   Carry chain, evaluated in one cycle:
//   - second 59->0 carries to minute; minute 59->0 carries to hour.
//   - hour 23->0 carries to day; day dim->1 carries to month.
//   - month 12->1 carries to year; year 99->0 sets century_pulse.
//   days_in_month (dim):
//   - Months 4, 6, 9, 11 have 30 days; month 2 has 28, or 29 if year[1:0]==0.
//   - All other months have 31 days.
//   - Year 00 (2000) is a leap year.
//   Set: on set_en=1, all fields are range-checked, including day against dim for set_month/set_year.
//   - Valid: all six registers load on the next edge; the prescaler clears to 0; no sec_pulse.
//   - Invalid: no register changes, including the prescaler; set_err pulses.
//   Priority: set_en beats a tick in the same cycle. The tick is discarded, not deferred.
//   run=0: the prescaler holds. set_en still works while run=0.
//   Any rst_n low mid-operation returns all state to reset values immediately, without waiting for clk.
//   All arithmetic is unsigned, at output width. No intermediate value exceeds the output width.
//   Day never exceeds dim. Every output stays in range under all input sequences.
// TESTING  (CLK_FREQ=4)
//   1. Reset, run=1, 8 clocks -> sec_pulse on cycles 5 and 9; second=1 then 2; other fields unchanged.
//   2. Set 31/12/99 23:59:59, then run until the next tick.
//      -> 01/01/00 00:00:00; century_pulse and sec_pulse both high for 1 cycle.
//   3. Set 28/02/24 23:59:59 and tick -> 29/02/24 00:00:00.
//      Set 28/02/23 23:59:59 and tick -> 01/03/23.
//   4. Set 30/04/05 23:59:59 and tick -> 01/05/05.
//      Then set_day=31 with set_month=4 -> set_err pulse; state unchanged.
//   5. Assert set_en in the same cycle as a tick.
//      -> loaded values appear; no sec_pulse; the next tick follows 4 cycles later.
//   6. run=0 for 10 cycles -> outputs frozen.
//      Then assert rst_n low between clock edges -> outputs reset to 01/01/00 00:00:00 before the next edge.

Source files
------------

// File: rtl/time_date_counter.sv
// Real-time clock and 2000-2099 calendar: divides clk down to a 1 Hz tick and keeps
// second/minute/hour/day/month/year in binary, with a range-checked full-date load.
module time_date_counter #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       set_en,
  input  logic [4:0] set_day,
  input  logic [3:0] set_month,
  input  logic [6:0] set_year,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_minute,
  input  logic [5:0] set_second,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic       sec_pulse,
  output logic       century_pulse,
  output logic       set_err
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);

  // February is 29 days whenever year[1:0]==0; 2000 is a leap year and the range ends at 2099.
  function automatic logic [4:0] f_dim(input logic [3:0] m, input logic [6:0] y);
    logic [4:0] d;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      4'd2:                    d = (y[1:0] == 2'd0) ? 5'd29 : 5'd28;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

  logic [PW-1:0] r_presc;
  logic [4:0]    r_day;
  logic [3:0]    r_month;
  logic [6:0]    r_year;
  logic [4:0]    r_hour;
  logic [5:0]    r_minute;
  logic [5:0]    r_second;
  logic          r_sec_pulse;
  logic          r_century_pulse;
  logic          r_set_err;

  logic          w_tick;
  logic          w_set_ok;
  logic [4:0]    w_dim_cur;
  logic          w_sec_wrap;
  logic          w_min_wrap;
  logic          w_hour_wrap;
  logic          w_day_wrap;
  logic          w_mon_wrap;
  logic          w_year_wrap;
  logic [5:0]    w_second_nxt;
  logic [5:0]    w_minute_nxt;
  logic [4:0]    w_hour_nxt;
  logic [4:0]    w_day_nxt;
  logic [3:0]    w_month_nxt;
  logic [6:0]    w_year_nxt;
  logic [PW-1:0] w_presc_nxt;

  assign w_tick      = run && (r_presc == PRESC_MAX);
  assign w_presc_nxt = (r_presc == PRESC_MAX) ? '0 : r_presc + PW'(1);

  assign w_set_ok = (set_month >= 4'd1) && (set_month <= 4'd12) &&
                    (set_year <= 7'd99) && (set_hour <= 5'd23) &&
                    (set_minute <= 6'd59) && (set_second <= 6'd59) &&
                    (set_day >= 5'd1) && (set_day <= f_dim(set_month, set_year));

  // Wrap on >= rather than == so every field stays bounded even from an unexpected value.
  assign w_dim_cur   = f_dim(r_month, r_year);
  assign w_sec_wrap  = (r_second >= 6'd59);
  assign w_min_wrap  = w_sec_wrap  && (r_minute >= 6'd59);
  assign w_hour_wrap = w_min_wrap  && (r_hour >= 5'd23);
  assign w_day_wrap  = w_hour_wrap && (r_day >= w_dim_cur);
  assign w_mon_wrap  = w_day_wrap  && (r_month >= 4'd12);
  assign w_year_wrap = w_mon_wrap  && (r_year >= 7'd99);

  assign w_second_nxt = w_sec_wrap ? 6'd0 : r_second + 6'd1;
  assign w_minute_nxt = !w_sec_wrap  ? r_minute : (w_min_wrap  ? 6'd0 : r_minute + 6'd1);
  assign w_hour_nxt   = !w_min_wrap  ? r_hour   : (w_hour_wrap ? 5'd0 : r_hour + 5'd1);
  assign w_day_nxt    = !w_hour_wrap ? r_day    : (w_day_wrap  ? 5'd1 : r_day + 5'd1);
  assign w_month_nxt  = !w_day_wrap  ? r_month  : (w_mon_wrap  ? 4'd1 : r_month + 4'd1);
  assign w_year_nxt   = !w_mon_wrap  ? r_year   : (w_year_wrap ? 7'd0 : r_year + 7'd1);

  // A load in the same cycle as a tick wins and the tick is dropped; a rejected load freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc         <= '0;
      r_day           <= 5'd1;
      r_month         <= 4'd1;
      r_year          <= 7'd0;
      r_hour          <= 5'd0;
      r_minute        <= 6'd0;
      r_second        <= 6'd0;
      r_sec_pulse     <= 1'b0;
      r_century_pulse <= 1'b0;
      r_set_err       <= 1'b0;
    end else begin
      r_sec_pulse     <= 1'b0;
      r_century_pulse <= 1'b0;
      r_set_err       <= 1'b0;
      if (set_en) begin
        if (w_set_ok) begin
          r_presc  <= '0;
          r_day    <= set_day;
          r_month  <= set_month;
          r_year   <= set_year;
          r_hour   <= set_hour;
          r_minute <= set_minute;
          r_second <= set_second;
        end else begin
          r_set_err <= 1'b1;
        end
      end else if (run) begin
        r_presc <= w_presc_nxt;
        if (w_tick) begin
          r_second        <= w_second_nxt;
          r_minute        <= w_minute_nxt;
          r_hour          <= w_hour_nxt;
          r_day           <= w_day_nxt;
          r_month         <= w_month_nxt;
          r_year          <= w_year_nxt;
          r_sec_pulse     <= 1'b1;
          r_century_pulse <= w_year_wrap;
        end
      end
    end
  end

  assign day           = r_day;
  assign month         = r_month;
  assign year          = r_year;
  assign hour          = r_hour;
  assign minute        = r_minute;
  assign second        = r_second;
  assign sec_pulse     = r_sec_pulse;
  assign century_pulse = r_century_pulse;
  assign set_err       = r_set_err;

endmodule
